// File: rtl/bu2020_data_memory.sv
// Single-port data memory on a shared tri-state CPU bus with a side preload port.
// Define DMEM_CLEAR_ON_RESET_EN to zero every word with a CLEAR sweep after each reset.
module bu2020_data_memory #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addressbus,
  inout  wire  [DATA_W-1:0] databus,
  input  logic              writemode,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              busy,
  output logic [15:0]       write_count
);

  logic [DATA_W-1:0] mem [(1 << ADDR_W)];

  logic [15:0]       write_count_q, write_count_d;
  logic              in_idle;
  logic              cpu_wr;
  logic              load_fire;
  logic              clear_wr;
  logic [ADDR_W-1:0] clear_addr;
  logic [DATA_W-1:0] rd_data;

`ifdef DMEM_CLEAR_ON_RESET_EN
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] sweep_q, sweep_d;

  // The sweep writes the top word on its last CLEAR cycle, then hands over to IDLE.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    if (state_q == ST_CLEAR) begin
      sweep_d = sweep_q + ADDR_W'(1);
      if (sweep_q == {ADDR_W{1'b1}}) begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  assign in_idle    = (state_q == ST_IDLE);
  assign busy       = (state_q == ST_CLEAR);
  assign clear_wr   = !rst && (state_q == ST_CLEAR);
  assign clear_addr = sweep_q;
`else
  assign in_idle    = 1'b1;
  assign busy       = 1'b0;
  assign clear_wr   = 1'b0;
  assign clear_addr = '0;
`endif

  // CPU writes own the cycle; a preload is only accepted on a CPU read cycle.
  assign cpu_wr     = !rst && in_idle && writemode;
  assign load_ready = !rst && in_idle && !writemode;
  assign load_fire  = load_valid && load_ready;

  assign rd_data = in_idle ? mem[addressbus] : '0;
  assign databus = writemode ? {DATA_W{1'bz}} : rd_data;

  always_comb begin
    write_count_d = write_count_q;
    if (cpu_wr && (write_count_q != 16'hFFFF)) begin
      write_count_d = write_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_count_q <= '0;
    end else begin
      write_count_q <= write_count_d;
    end
  end

  assign write_count = write_count_q;

  // Storage has no reset: contents only change through the three write paths.
  always_ff @(posedge clk) begin
    if (clear_wr) begin
      mem[clear_addr] <= '0;
    end else if (cpu_wr) begin
      mem[addressbus] <= databus;
    end else if (load_fire) begin
      mem[load_addr] <= load_data;
    end
  end

endmodule

// File: tb/tb_bu2020_data_memory.sv
// Directed bench for bu2020_data_memory: driver tasks queue expectations, a negedge monitor checks them.
// Sweep-related checks are built when DMEM_CLEAR_ON_RESET_EN is defined.
module tb_bu2020_data_memory;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam int K_DATA = 0;
  localparam int K_WCNT = 1;
  localparam int K_BUSY = 2;
  localparam int K_LRDY = 3;
`ifdef DMEM_CLEAR_ON_RESET_EN
  localparam logic [DATA_W-1:0] BUSY_IN_RST = 16'd1;
`else
  localparam logic [DATA_W-1:0] BUSY_IN_RST = 16'd0;
`endif

  // clock / reset
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [ADDR_W-1:0] addressbus;
  logic              writemode;
  logic              load_valid;
  logic              load_ready;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              busy;
  logic [15:0]       write_count;
  logic [DATA_W-1:0] tb_data;
  logic              tb_drive;
  wire  [DATA_W-1:0] databus;

  assign databus = tb_drive ? tb_data : {DATA_W{1'bz}};

  bu2020_data_memory #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .addressbus (addressbus),
    .databus    (databus),
    .writemode  (writemode),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .busy       (busy),
    .write_count(write_count)
  );

  // scoreboard
  logic [DATA_W-1:0] exp_q[$];
  int                kind_q[$];
  string             name_q[$];
  logic              chk_en;
  int                total;
  int                bad;
  logic [DATA_W-1:0] mon_exp;
  logic [DATA_W-1:0] mon_act;
  int                mon_kind;
  string             mon_name;

  function automatic void check(string name, logic [DATA_W-1:0] act, logic [DATA_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      while (exp_q.size() > 0) begin
        mon_exp  = exp_q.pop_front();
        mon_kind = kind_q.pop_front();
        mon_name = name_q.pop_front();
        case (mon_kind)
          K_DATA:  mon_act = databus;
          K_WCNT:  mon_act = write_count;
          K_BUSY:  mon_act = {15'd0, busy};
          default: mon_act = {15'd0, load_ready};
        endcase
        check(mon_name, mon_act, mon_exp);
      end
    end
  end

  // driver tasks
  task automatic expect_now(input int kind, input logic [DATA_W-1:0] e, input string n);
    exp_q.push_back(e);
    kind_q.push_back(kind);
    name_q.push_back(n);
    chk_en = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    chk_en = 1'b0;
  endtask

  task automatic idle_inputs();
    writemode  = 1'b0;
    tb_drive   = 1'b0;
    load_valid = 1'b0;
  endtask

  task automatic cpu_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    addressbus = a;
    tb_data    = d;
    load_valid = 1'b0;
    writemode  = 1'b1;
    tb_drive   = 1'b1;
    step();
    idle_inputs();
  endtask

  task automatic cpu_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] e, input string n);
    idle_inputs();
    addressbus = a;
    expect_now(K_DATA, e, n);
    step();
  endtask

  task automatic peek(input int kind, input logic [DATA_W-1:0] e, input string n);
    expect_now(kind, e, n);
    step();
  endtask

  // Preload offered on a read cycle; the same-cycle read of rd_a must show rd_e.
  task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                         input logic [ADDR_W-1:0] rd_a, input logic [DATA_W-1:0] rd_e,
                         input logic exp_rdy, input string n);
    idle_inputs();
    addressbus = rd_a;
    load_addr  = a;
    load_data  = d;
    load_valid = 1'b1;
    expect_now(K_LRDY, {15'd0, exp_rdy}, {n, " load_ready"});
    expect_now(K_DATA, rd_e, {n, " same-cycle read"});
    step();
    load_valid = 1'b0;
  endtask

  task automatic reset_pulse();
    idle_inputs();
    rst = 1'b1;
    expect_now(K_WCNT, 16'd0, "rst write_count");
    expect_now(K_LRDY, 16'd0, "rst load_ready");
    expect_now(K_BUSY, BUSY_IN_RST, "rst busy");
    step();
    rst = 1'b0;
  endtask

  task automatic measure_busy(input int exp_cycles, input string n);
    int cnt;
    cnt = 0;
    while (cnt < 5000) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      cnt++;
    end
    @(posedge clk);
    #1;
    check(n, cnt[15:0], exp_cycles[15:0]);
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    chk_en     = 1'b0;
    rst        = 1'b1;
    addressbus = '0;
    load_addr  = '0;
    load_data  = '0;
    tb_data    = '0;
    idle_inputs();
    step();
    step();
    reset_pulse();

`ifdef DMEM_CLEAR_ON_RESET_EN
    measure_busy(4096, "first sweep length");
    cpu_read(12'h000, 16'h0000, "cleared 0x000");
    cpu_read(12'h555, 16'h0000, "cleared 0x555");
    cpu_read(12'hFFF, 16'h0000, "cleared 0xFFF");
`else
    peek(K_BUSY, 16'd0, "busy tied low");
`endif

    cpu_write(12'h123, 16'hBEEF);
    peek(K_WCNT, 16'd1, "write_count after first write");
    cpu_read(12'h123, 16'hBEEF, "read back 0x123");

    preload(12'h010, 16'h1111, 12'h123, 16'hBEEF, 1'b1, "preload 0x010");
    preload(12'h123, 16'h7777, 12'h123, 16'hBEEF, 1'b1, "preload over 0x123");
    cpu_read(12'h123, 16'h7777, "new preload visible");
    peek(K_WCNT, 16'd1, "write_count after preloads");

    // CPU write and preload offered together: the CPU write wins.
    addressbus = 12'h020;
    tb_data    = 16'h2222;
    load_addr  = 12'h010;
    load_data  = 16'h5555;
    load_valid = 1'b1;
    writemode  = 1'b1;
    tb_drive   = 1'b1;
    expect_now(K_LRDY, 16'd0, "conflict load_ready");
    step();
    idle_inputs();
    peek(K_WCNT, 16'd2, "write_count after conflict");
    cpu_read(12'h020, 16'h2222, "conflict CPU write");
    cpu_read(12'h010, 16'h1111, "conflict load dropped");

    preload(12'hFFF, 16'h0ABC, 12'h020, 16'h2222, 1'b1, "preload top");
    cpu_read(12'hFFF, 16'h0ABC, "read top address");
    peek(K_WCNT, 16'd2, "write_count after top preload");

    for (int i = 0; i < 65533; i++) begin
      cpu_write(12'h300, i[15:0]);
    end
    peek(K_WCNT, 16'hFFFF, "write_count reaches max");
    for (int i = 0; i < 5; i++) begin
      cpu_write(12'h300, 16'h4000 + i[15:0]);
    end
    peek(K_WCNT, 16'hFFFF, "write_count saturated");
    cpu_read(12'h300, 16'h4004, "last saturating write");

    reset_pulse();
`ifdef DMEM_CLEAR_ON_RESET_EN
    cpu_read(12'h123, 16'h0000, "read during sweep");
    cpu_write(12'h123, 16'hDEAD);
    preload(12'h200, 16'h9999, 12'h020, 16'h0000, 1'b0, "preload during sweep");
    peek(K_WCNT, 16'd0, "write ignored in sweep");
    repeat (2044) step();
    peek(K_BUSY, 16'd1, "busy at sweep 0x800");
    reset_pulse();
    measure_busy(4096, "restarted sweep length");
    cpu_read(12'h123, 16'h0000, "0x123 after restart");
    cpu_read(12'h200, 16'h0000, "0x200 after restart");
    cpu_read(12'h300, 16'h0000, "0x300 after restart");
`else
    cpu_read(12'h123, 16'h7777, "0x123 kept over reset");
    cpu_read(12'h300, 16'h4004, "0x300 kept over reset");
    peek(K_WCNT, 16'd0, "write_count after reset");
`endif

    step();
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard drain: got %0d left expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
